// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Ports: clk, rst_n, in_valid/in_ready/bin_in, out_valid/out_ready,
//        bcd_out (digit 0 in [3:0]), neg_out, ndigits.
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3,
    parameter int SIGNED = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              bin_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [4*DIGITS-1:0]           bcd_out,
    output logic                          neg_out,
    output logic [$clog2(DIGITS+1)-1:0]   ndigits
);

    localparam int NDW = $clog2(DIGITS + 1);
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int BW  = 4 * DIGITS;

    // Saturating power of ten so large DIGITS cannot overflow the check.
    function automatic bit f_fits();
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < DIGITS; i++) begin
            if (p < (64'd1 << 40)) p = p * 64'd10;
        end
        return p > ((64'd1 << WIDTH) - 64'd1);
    endfunction

    localparam bit FITS = f_fits();

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("bin2bcd_seq: WIDTH must be 2..32");
        end
        if (!FITS) begin : g_bad_digits
            $error("bin2bcd_seq: DIGITS too small for WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_mag;
    logic [BW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_sign;
    logic [BW-1:0]    r_bcd;
    logic             r_neg;
    logic [NDW-1:0]   r_nd;

    logic [WIDTH-1:0] w_neg_in;
    logic             w_in_neg;
    logic [WIDTH-1:0] w_mag_in;
    logic [BW-1:0]    w_adj;
    logic [BW-1:0]    w_acc_sh;
    logic [WIDTH-1:0] w_mag_sh;
    logic [NDW-1:0]   w_nd;
    logic             w_accept;
    logic             w_last;

    // Most negative input negates to itself, which read unsigned is
    // exactly the required magnitude.
    assign w_neg_in = -bin_in;
    assign w_in_neg = (SIGNED != 0) && bin_in[WIDTH-1];
    assign w_mag_in = w_in_neg ? w_neg_in : bin_in;

    always_comb begin
        w_adj = r_acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_acc[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
            end
        end
    end

    assign w_acc_sh = {w_adj[BW-2:0], r_mag[WIDTH-1]};
    assign w_mag_sh = {r_mag[WIDTH-2:0], 1'b0};

    // Highest non-zero digit of the final value; zero still shows one digit.
    always_comb begin
        w_nd = NDW'(1);
        for (int d = 0; d < DIGITS; d++) begin
            if (w_acc_sh[4*d +: 4] != 4'd0) w_nd = NDW'(d + 1);
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_SHIFT;
            end
            S_SHIFT: begin
                if (r_cnt == CW'(1)) w_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_last   = (r_state == S_SHIFT) && (r_cnt == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mag  <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_sign <= 1'b0;
        end else if (w_accept) begin
            r_mag  <= w_mag_in;
            r_acc  <= '0;
            r_cnt  <= CW'(WIDTH);
            r_sign <= w_in_neg;
        end else if (r_state == S_SHIFT) begin
            r_mag <= w_mag_sh;
            r_acc <= w_acc_sh;
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // Result registers load only on the final shift, so they keep the
    // previous result while a new conversion is running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd <= '0;
            r_neg <= 1'b0;
            r_nd  <= NDW'(1);
        end else if (w_last) begin
            r_bcd <= w_acc_sh;
            r_neg <= r_sign;
            r_nd  <= w_nd;
        end
    end

    assign bcd_out = r_bcd;
    assign neg_out = r_neg;
    assign ndigits = r_nd;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq: unsigned 8-bit, signed 8-bit and 16-bit
// instances checked against an arithmetic decimal model.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  iv = 3'b000;
    logic [2:0]  ordy = 3'b111;
    logic [15:0] bin = 16'h0000;
    int          sel = 0;

    logic        a_ir, a_ov, a_neg;
    logic [11:0] a_bcd;
    logic [1:0]  a_nd;
    logic        b_ir, b_ov, b_neg;
    logic [11:0] b_bcd;
    logic [1:0]  b_nd;
    logic        c_ir, c_ov, c_neg;
    logic [19:0] c_bcd;
    logic [2:0]  c_nd;

    logic        m_ir, m_ov, m_neg;
    logic [19:0] m_bcd;
    logic [2:0]  m_nd;

    int nvec = 0;
    int nmis = 0;
    logic [19:0] last_bcd = 20'h0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(0)) u_u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(a_ir),
        .bin_in(bin[7:0]), .out_valid(a_ov), .out_ready(ordy[0]),
        .bcd_out(a_bcd), .neg_out(a_neg), .ndigits(a_nd));

    bin2bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1)) u_s8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(b_ir),
        .bin_in(bin[7:0]), .out_valid(b_ov), .out_ready(ordy[1]),
        .bcd_out(b_bcd), .neg_out(b_neg), .ndigits(b_nd));

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(0)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(c_ir),
        .bin_in(bin), .out_valid(c_ov), .out_ready(ordy[2]),
        .bcd_out(c_bcd), .neg_out(c_neg), .ndigits(c_nd));

    always_comb begin
        m_ir = a_ir; m_ov = a_ov; m_neg = a_neg;
        m_bcd = {8'h0, a_bcd}; m_nd = {1'b0, a_nd};
        if (sel == 1) begin
            m_ir = b_ir; m_ov = b_ov; m_neg = b_neg;
            m_bcd = {8'h0, b_bcd}; m_nd = {1'b0, b_nd};
        end else if (sel == 2) begin
            m_ir = c_ir; m_ov = c_ov; m_neg = c_neg;
            m_bcd = c_bcd; m_nd = c_nd;
        end
    end

    function automatic logic [19:0] ref_bcd(longint unsigned v);
        logic [19:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int ref_nd(longint unsigned v);
        int n;
        n = 1;
        while (v >= 10) begin
            v = v / 10;
            n++;
        end
        return n;
    endfunction

    function automatic bit ref_neg(int w, bit sg, longint unsigned v);
        return sg && (((v >> (w - 1)) & 64'd1) == 64'd1);
    endfunction

    function automatic longint unsigned ref_mag(int w, bit sg,
                                                longint unsigned v);
        if (ref_neg(w, sg, v)) return (64'd1 << w) - v;
        return v;
    endfunction

    // One full conversion on instance s with out_ready held high.
    task automatic convert(input int s, input int w, input bit sg,
                           input longint unsigned v);
        longint unsigned mag;
        int k;
        mag = ref_mag(w, sg, v);
        sel = s;
        bin = 16'(v);
        iv = 3'b000;
        iv[s] = 1'b1;
        #0;
        nvec++;
        if (m_ir !== 1'b1) begin
            nmis++;
            $display("FAIL in_ready_idle: got %b expected 1", m_ir);
        end
        @(posedge clk); #1;
        iv = 3'b000;
        k = 0;
        while (m_ov !== 1'b1 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        nvec++;
        if (k !== w) begin
            nmis++;
            $display("FAIL latency v=%0h: got %0d expected %0d", v, k, w);
        end
        nvec++;
        if (m_bcd !== ref_bcd(mag)) begin
            nmis++;
            $display("FAIL bcd v=%0h: got %h expected %h",
                     v, m_bcd, ref_bcd(mag));
        end
        nvec++;
        if (m_neg !== ref_neg(w, sg, v)) begin
            nmis++;
            $display("FAIL neg v=%0h: got %b expected %b",
                     v, m_neg, ref_neg(w, sg, v));
        end
        nvec++;
        if (int'(m_nd) !== ref_nd(mag)) begin
            nmis++;
            $display("FAIL ndigits v=%0h: got %0d expected %0d",
                     v, m_nd, ref_nd(mag));
        end
        last_bcd = ref_bcd(mag);
        @(posedge clk); #1;
        nvec++;
        if (m_ov !== 1'b0 || m_ir !== 1'b1) begin
            nmis++;
            $display("FAIL release v=%0h: got ov=%b ir=%b expected ov=0 ir=1",
                     v, m_ov, m_ir);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nvec++;
        if (a_ir !== 1'b1 || a_ov !== 1'b0) begin
            nmis++;
            $display("FAIL reset_hs: got ir=%b ov=%b expected ir=1 ov=0",
                     a_ir, a_ov);
        end
        nvec++;
        if (a_bcd !== 12'h000 || a_nd !== 2'd1 || a_neg !== 1'b0) begin
            nmis++;
            $display("FAIL reset_out: got bcd=%h nd=%0d neg=%b expected 000 1 0",
                     a_bcd, a_nd, a_neg);
        end
        nvec++;
        if (c_bcd !== 20'h0 || c_nd !== 3'd1 || b_neg !== 1'b0) begin
            nmis++;
            $display("FAIL reset_other: got bcd=%h nd=%0d neg=%b expected 0 1 0",
                     c_bcd, c_nd, b_neg);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        convert(0, 8, 1'b0, 64'hFF);
        convert(0, 8, 1'b0, 64'hA5);
        convert(0, 8, 1'b0, 64'h05);
        convert(0, 8, 1'b0, 64'h00);
        for (int i = 0; i < 20; i++) begin
            convert(0, 8, 1'b0, longint'($urandom_range(0, 255)));
        end
    endtask

    task automatic test_signed();
        convert(1, 8, 1'b1, 64'h80);
        convert(1, 8, 1'b1, 64'hF6);
        convert(1, 8, 1'b1, 64'h7F);
        for (int i = 0; i < 20; i++) begin
            convert(1, 8, 1'b1, longint'($urandom_range(0, 255)));
        end
    endtask

    task automatic test_backpressure();
        int k;
        sel = 0;
        ordy[0] = 1'b0;
        bin = 16'h000C;
        iv[0] = 1'b1;
        @(posedge clk); #1;
        bin = 16'h0099;
        k = 0;
        while (a_ov !== 1'b1 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        nvec++;
        if (k !== 8) begin
            nmis++;
            $display("FAIL bp_latency: got %0d expected 8", k);
        end
        for (int i = 0; i < 5; i++) begin
            nvec++;
            if (a_bcd !== 12'h012 || a_ov !== 1'b1 || a_ir !== 1'b0) begin
                nmis++;
                $display("FAIL bp_hold %0d: got bcd=%h ov=%b ir=%b expected 012 1 0",
                         i, a_bcd, a_ov, a_ir);
            end
            @(posedge clk); #1;
        end
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        nvec++;
        if (a_ov !== 1'b0 || a_ir !== 1'b1 || a_bcd !== 12'h012) begin
            nmis++;
            $display("FAIL bp_release: got ov=%b ir=%b bcd=%h expected 0 1 012",
                     a_ov, a_ir, a_bcd);
        end
        iv[0] = 1'b0;
        last_bcd = 20'h00012;
        @(posedge clk); #1;
        nvec++;
        if (a_ir !== 1'b1) begin
            nmis++;
            $display("FAIL bp_idle: got ir=%b expected 1", a_ir);
        end
    endtask

    task automatic test_reset_midop();
        sel = 0;
        bin = 16'h00C8;
        iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        nvec++;
        if (a_bcd !== last_bcd[11:0] || a_ov !== 1'b0 || a_ir !== 1'b0) begin
            nmis++;
            $display("FAIL midop_retain: got bcd=%h ov=%b ir=%b expected %h 0 0",
                     a_bcd, a_ov, a_ir, last_bcd[11:0]);
        end
        rst_n = 1'b0;
        #1;
        nvec++;
        if (a_ir !== 1'b1 || a_ov !== 1'b0 || a_bcd !== 12'h000 ||
            a_nd !== 2'd1 || a_neg !== 1'b0) begin
            nmis++;
            $display("FAIL midop_reset: got ir=%b ov=%b bcd=%h nd=%0d expected 1 0 000 1",
                     a_ir, a_ov, a_bcd, a_nd);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        convert(0, 8, 1'b0, 64'h01);
    endtask

    task automatic test_wide();
        convert(2, 16, 1'b0, 64'hFFFF);
        convert(2, 16, 1'b0, 64'h0000);
        for (int i = 0; i < 8; i++) begin
            convert(2, 16, 1'b0, longint'($urandom_range(0, 65535)));
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        logic [7:0] e;
        logic       ir;
        int cyc, last, nres;
        sel = 0;
        ordy[0] = 1'b1;
        bin = 16'($urandom_range(0, 255));
        iv[0] = 1'b1;
        cyc = 0; last = -1; nres = 0;
        while (nres < 6 && cyc < 200) begin
            ir = a_ir;
            @(posedge clk); #1;
            cyc++;
            if (ir) begin
                q.push_back(bin[7:0]);
                bin = 16'($urandom_range(0, 255));
            end
            if (a_ov && q.size() > 0) begin
                e = q.pop_front();
                nvec++;
                if (a_bcd !== ref_bcd(longint'(e))) begin
                    nmis++;
                    $display("FAIL b2b_bcd v=%0h: got %h expected %h",
                             e, a_bcd, ref_bcd(longint'(e)));
                end
                if (last >= 0) begin
                    nvec++;
                    if (cyc - last !== 10) begin
                        nmis++;
                        $display("FAIL b2b_interval: got %0d expected 10",
                                 cyc - last);
                    end
                end
                last = cyc;
                nres++;
            end
        end
        nvec++;
        if (nres < 6) begin
            nmis++;
            $display("FAIL b2b_timeout: got %0d results expected 6", nres);
        end
        iv[0] = 1'b0;
        repeat (12) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_backpressure();
        test_reset_midop();
        test_wide();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Parametrised sequential binary-to-BCD converter for the vending machine's display path. It accepts a WIDTH-bit binary value (credit, price, change) and produces DIGITS packed BCD digits, a sign flag and a significant-digit count for the seven-segment driver. Conversion is iterative shift-add-3 (double dabble), one bit per clock. Transfers on both sides use valid/ready handshakes.

## Interface
- WIDTH, 8: input binary width; legal range 2..32.
- DIGITS, 3: BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH - 1; elaboration fails otherwise.
- SIGNED, 0: 1 means the input is two's complement; the output is sign plus magnitude.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  bin_in is valid.
- in_ready  out  1  block can accept an input (IDLE only).
- bin_in  in  WIDTH  binary value to convert.
- out_valid  out  1  result is valid (DONE only).
- out_ready  in  1  consumer accepts the result.
- bcd_out  out  4*DIGITS  packed BCD; digit 0 (units) is in bits [3:0].
- neg_out  out  1  input was negative (always 0 when SIGNED=0).
- ndigits  out  clog2(DIGITS+1)  index of the most significant non-zero digit plus 1; minimum 1 (value 0 gives 1).

## Operation
- The FSM has three states: IDLE, SHIFT, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid&&in_ready:
    - Capture magnitude into the shift register: bin_in, or -bin_in when SIGNED and bin_in[WIDTH-1]=1.
    - Capture the sign.
    - Clear the BCD accumulator.
    - Set bit counter to WIDTH.
    - Go to SHIFT.
- **Magnitude width**
  - The magnitude register is WIDTH bits unsigned.
  - -2^(WIDTH-1) yields magnitude 2^(WIDTH-1), with no overflow.
- **SHIFT**, once per cycle:
  - Every accumulator digit ≥5 gets +3.
  - Then shift {accumulator, magnitude} left 1.
  - Decrement the counter.
  - When the counter reaches 1, the next edge enters DONE with the final shift applied.
- **DONE**
  - out_valid=1.
  - bcd_out, neg_out and ndigits are stable and held until out_valid&&out_ready.
  - Then go to IDLE.
- **ndigits** is computed from the final accumulator on entry to DONE (registered).
- **Unaccepted input:** in_valid while in_ready=0 is ignored. No queuing, no error.
- **out_ready while not in DONE** has no effect.
- **Output values outside DONE:** bcd_out, neg_out and ndigits are registered and retain the last result. Only out_valid qualifies them.

## Timing
- **Reset values:**
  - state=IDLE, in_ready=1, out_valid=0.
  - bcd_out=0, neg_out=0, ndigits=1.
  - Internal counters and registers are 0.
- **Reset mid-operation** (SHIFT or DONE): the conversion is aborted asynchronously and all outputs take their reset values immediately. No output is produced for the aborted input.
- **Latency:**
  - Accepting edge E0.
  - SHIFT on edges E1..E(WIDTH).
  - out_valid rises after edge E(WIDTH), i.e. WIDTH cycles after acceptance.
- **Release:**
  - out_valid&&out_ready at edge Ed sets IDLE after Ed; in_ready=1 in the following cycle.
  - A new input is accepted no earlier than edge Ed+1.
- **Throughput:** one conversion per WIDTH+2 cycles with out_ready held high.
- **Backpressure:** with out_ready=0, DONE is held indefinitely and outputs do not change.
- **Simultaneous events:** in_valid and out_ready high in the same DONE cycle: only the output handshake occurs; the input is not taken until IDLE.

## Test plan
- **Reset:** WIDTH=8, DIGITS=3, SIGNED=0; hold rst_n=0.
  - Required: in_ready=1, out_valid=0, bcd_out=12'h000, ndigits=1.
- **Basic conversions:** send 8'hFF, 8'hA5, 8'h05, 8'h00 with out_ready=1.
  - Required bcd_out: 12'h255 (ndigits 3), 12'h165 (3), 12'h005 (1), 12'h000 (1).
  - out_valid must rise exactly 8 cycles after each accept.
- **Signed mode:** SIGNED=1; send 8'h80, 8'hF6, 8'h7F.
  - 8'h80 -> neg_out=1, 12'h128.
  - 8'hF6 -> neg_out=1, 12'h010, ndigits=2.
  - 8'h7F -> neg_out=0, 12'h127.
- **Backpressure:** convert 8'h0C with out_ready=0 for 5 cycles.
  - bcd_out=12'h012 held stable and in_ready=0 throughout.
  - in_valid pulses with 8'h99 during SHIFT/DONE are ignored.
  - After out_ready=1, IDLE follows.
- **Reset mid-op:** assert rst_n=0 three cycles after accepting 8'hC8.
  - Outputs return to reset values immediately.
  - After release, 8'h01 converts to 12'h001 with no stale data.
- **Wide parameter:** WIDTH=16, DIGITS=5; send 16'hFFFF.
  - Required: bcd_out=20'h65535, ndigits=5, latency 16 cycles.
